// File: rtl/master_cmd_queue.sv
// Command sequencer feeding master_port: queues read/write commands, issues them
// one at a time, returns read data through a single-entry response register.
module master_cmd_queue #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        m_start,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wr_data,
  output logic        m_mode,
  input  logic [7:0]  m_rd_data,
  input  logic        m_done,
  output logic        busy,
  output logic [7:0]  timeout_cnt,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on any rising edge where valid && ready are
  // both high; valid never depends on ready, and the payload is stable while valid.

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [24:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [24:0] head;
  logic [15:0] wd_cnt;
  logic        wd_hit;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign busy      = (state != S_IDLE) || !empty;
  assign dbg_state = state;
  // wd_cnt counts cycles since m_start rose, so the abort lands TIMEOUT edges later
  assign wd_hit    = (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_mode, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (!empty) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (m_done || wd_hit) state_nxt = m_mode ? S_IDLE : S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_start     <= 1'b0;
      m_addr      <= '0;
      m_wr_data   <= '0;
      m_mode      <= 1'b0;
      wd_cnt      <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      m_start <= pop;
      if (pop) begin
        {m_mode, m_addr, m_wr_data} <= head;
        wd_cnt <= '0;
      end else if (state == S_LAUNCH || (state == S_WAIT && !m_done && !wd_hit)) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      // m_done takes priority over a watchdog expiry in the same cycle
      if (state == S_WAIT) begin
        if (m_done) begin
          if (!m_mode) begin
            rsp_valid <= 1'b1;
            rsp_data  <= m_rd_data;
            rsp_err   <= 1'b0;
          end
        end else if (wd_hit) begin
          if (timeout_cnt != 8'hff) timeout_cnt <= timeout_cnt + 8'd1;
          if (!m_mode) begin
            rsp_valid <= 1'b1;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b1;
          end
        end
      end
      if (state == S_RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_master_cmd_queue.sv
// Directed bench for master_cmd_queue: scoreboard queues for launches and read
// responses, checked by monitors as the DUT presents them.
module tb_master_cmd_queue;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_mode = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        m_start;
  logic [15:0] m_addr;
  logic [7:0]  m_wr_data;
  logic        m_mode;
  logic [7:0]  m_rd_data = '0;
  logic        m_done = 1'b0;
  logic        busy;
  logic [7:0]  timeout_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [24:0] exp_q[$];       // expected launches {mode, addr, wdata}
  logic [8:0]  exp_rsp_q[$];   // expected responses {err, data}
  logic [24:0] last_launch = '0;

  always #5 clk = ~clk;

  master_cmd_queue #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_start(m_start), .m_addr(m_addr), .m_wr_data(m_wr_data), .m_mode(m_mode),
    .m_rd_data(m_rd_data), .m_done(m_done),
    .busy(busy), .timeout_cnt(timeout_cnt), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic mode, input logic [15:0] addr, input logic [7:0] wdata);
    int n = 0;
    logic ok = 1'b0;
    cmd_mode = mode; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
    do begin
      ok = cmd_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    cmd_valid = 1'b0;
    chk("push_accept", {31'd0, ok}, 1);
    if (ok) exp_q.push_back({mode, addr, wdata});
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (!m_start && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  // m_done is sampled at the n-th edge after the m_start rising edge
  task automatic complete(input int n, input logic [7:0] d);
    repeat (n - 1) tick();
    m_done = 1'b1; m_rd_data = d;
    tick();
    m_done = 1'b0; m_rd_data = 8'h00;
  endtask

  task automatic finish_when_waiting(input int n);
    int b = 0;
    while (dbg_state != 2'd2 && b < 50) begin
      tick();
      b++;
    end
    chk("reach_wait", {30'd0, dbg_state}, 2);
    repeat (n) tick();
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 1);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 0);
    chk({tag, "_m_start"}, {31'd0, m_start}, 0);
    chk({tag, "_m_launch_regs"}, {7'd0, m_mode, m_addr, m_wr_data}, 0);
    chk({tag, "_rsp"}, {22'd0, rsp_valid, rsp_err, rsp_data}, 0);
    chk({tag, "_timeout_cnt"}, {24'd0, timeout_cnt}, 0);
  endtask

  // Launch monitor: every m_start pulse must match the oldest pushed command
  always @(negedge clk) begin
    if (rstn && m_start) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL launch_unexpected actual=%h required=none", {m_mode, m_addr, m_wr_data});
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        chk("launch_mode", {31'd0, m_mode}, {31'd0, e[24]});
        chk("launch_addr", {16'd0, m_addr}, {16'd0, e[23:8]});
        if (e[24]) chk("launch_wdata", {24'd0, m_wr_data}, {24'd0, e[7:0]});
      end
      last_launch = {m_mode, m_addr, m_wr_data};
    end
  end

  // Launch registers must hold while master_port is working
  always @(negedge clk) begin
    if (rstn && dbg_state == 2'd2)
      chk("launch_hold", {7'd0, m_mode, m_addr, m_wr_data}, {7'd0, last_launch});
  end

  // Response monitor: compare on each rsp handshake
  always @(negedge clk) begin
    if (rstn && rsp_valid && rsp_ready) begin
      if (exp_rsp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_unexpected actual=%h required=none", {rsp_err, rsp_data});
      end else begin
        logic [8:0] r;
        r = exp_rsp_q.pop_front();
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, r[7:0]});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, r[8]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int lat;
    logic seen;

    repeat (3) tick();
    check_reset("por");
    rstn = 1'b1;
    tick();

    // single write
    push(1'b1, 16'hcbcd, 8'hd3);
    chk("wr_busy", {31'd0, busy}, 1);
    wait_start(lat);
    chk("wr_latency", lat, 1);
    complete(5, 8'h00);
    chk("wr_idle", {30'd0, dbg_state}, 0);
    chk("wr_no_rsp", {31'd0, rsp_valid}, 0);
    chk("wr_not_busy", {31'd0, busy}, 0);

    // spurious m_done in IDLE
    m_done = 1'b1; m_rd_data = 8'h77;
    tick();
    m_done = 1'b0; m_rd_data = 8'h00;
    chk("spur_idle_state", {30'd0, dbg_state}, 0);
    chk("spur_idle_rsp", {22'd0, rsp_valid, rsp_err, rsp_data}, 0);
    chk("spur_idle_start", {31'd0, m_start}, 0);

    // read with 15-cycle completion, response held then consumed
    push(1'b0, 16'hcbcd, 8'h00);
    exp_rsp_q.push_back({1'b0, 8'hd3});
    wait_start(lat);
    chk("rd_latency", lat, 1);
    complete(15, 8'hd3);
    chk("rd_rsp_valid", {31'd0, rsp_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin m_done = 1'b1; m_rd_data = 8'hee; end
      tick();
      m_done = 1'b0; m_rd_data = 8'h00;
      chk("rd_hold", {22'd0, rsp_valid, rsp_err, rsp_data}, {22'd0, 1'b1, 1'b0, 8'hd3});
      chk("rd_hold_state", {30'd0, dbg_state}, 3);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd_cleared", {31'd0, rsp_valid}, 0);

    // full FIFO, back-to-back writes, pointer wrap over 10 commands
    for (int i = 0; i < 5; i++) push(1'b1, 16'h1000 + 16'(i), 8'h10 + 8'(i));
    chk("full_cmd_ready", {31'd0, cmd_ready}, 0);
    cmd_valid = 1'b1; cmd_addr = 16'hdead;
    tick();
    cmd_valid = 1'b0;
    chk("full_still_blocked", {31'd0, cmd_ready}, 0);
    for (int i = 0; i < 10; i++) begin
      finish_when_waiting(3);
      if (i < 9) begin
        chk("gap_idle_start", {31'd0, m_start}, 0);
        chk("gap_idle_state", {30'd0, dbg_state}, 0);
        tick();
        chk("gap_start", {31'd0, m_start}, 1);
        if (i + 5 < 10) push(1'b1, 16'h1000 + 16'(i + 5), 8'h10 + 8'(i + 5));
      end
    end
    tick();
    chk("b2b_done_busy", {31'd0, busy}, 0);

    // read timeout
    push(1'b0, 16'h2222, 8'h00);
    exp_rsp_q.push_back({1'b1, 8'h00});
    wait_start(lat);
    repeat (TIMEOUT - 1) tick();
    chk("to_not_yet", {31'd0, rsp_valid}, 0);
    tick();
    chk("to_rsp", {22'd0, rsp_valid, rsp_err, rsp_data}, {22'd0, 1'b1, 1'b1, 8'h00});
    chk("to_count1", {24'd0, timeout_cnt}, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // m_done on the exact timeout cycle wins
    push(1'b0, 16'h3333, 8'h00);
    exp_rsp_q.push_back({1'b0, 8'h5a});
    wait_start(lat);
    chk("to2_latency", lat, 1);
    complete(TIMEOUT, 8'h5a);
    chk("to2_rsp", {22'd0, rsp_valid, rsp_err, rsp_data}, {22'd0, 1'b1, 1'b0, 8'h5a});
    chk("to2_count", {24'd0, timeout_cnt}, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // write timeout returns to IDLE with no response
    push(1'b1, 16'h4444, 8'h44);
    wait_start(lat);
    repeat (TIMEOUT) tick();
    chk("wto_state", {30'd0, dbg_state}, 0);
    chk("wto_count", {24'd0, timeout_cnt}, 2);
    chk("wto_no_rsp", {31'd0, rsp_valid}, 0);

    // asynchronous reset mid-WAIT with 3 commands queued
    for (int i = 0; i < 4; i++) push(1'b1, 16'h5000 + 16'(i), 8'h50 + 8'(i));
    while (dbg_state != 2'd2) tick();
    repeat (3) tick();
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check_reset("mid");
    tick();
    tick();
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | m_start;
    end
    chk("post_rst_no_start", {31'd0, seen}, 0);
    chk("post_rst_ready", {31'd0, cmd_ready}, 1);
    chk("post_rst_busy", {31'd0, busy}, 0);
    push(1'b1, 16'h6060, 8'h66);
    wait_start(lat);
    chk("post_rst_latency", lat, 1);
    complete(4, 8'h00);
    tick();

    chk("launch_q_drained", exp_q.size(), 0);
    chk("rsp_q_drained", exp_rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
